fir_sample_feeder: RTL

Upstream pacing stage for the FIR filter. Accepts bursty samples over a valid/ready handshake, buffers them in a small synchronous FIFO, and issues them one at a time as a single-cycle `inputValid` pulse. It waits for the filter's `outputValid` completion pulse before releasing the next sample, so the multi-cycle MAC sequence is never overrun.

---
 rtl/fir_feeder_pkg.sv | 18 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fir_sample_feeder.sv | 92 +++++++++
 3 files changed

// File: rtl/fir_feeder_pkg.sv
// Shared types and width helpers for the FIR sample feeder.
package fir_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } feeder_state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy counter.
// The head entry is visible combinationally (no output register).
module sync_fifo
    import fir_feeder_pkg::*;
#(
    parameter int InputWidth = 16,
    parameter int FifoDepth  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [InputWidth-1:0]     data,
    output logic [InputWidth-1:0]     head,
    output logic [$clog2(FifoDepth):0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int PtrW = ptr_width(FifoDepth);
    localparam int LvlW = level_width(FifoDepth);

    logic [InputWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == LvlW'(FifoDepth));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LvlW'(1);
                2'b01:   level <= level - LvlW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces buffered samples into the FIR: one inputValid pulse per sample,
// holding the next one back until the FIR signals completion.
module fir_sample_feeder
    import fir_feeder_pkg::*;
#(
    parameter int InputWidth = 16,
    parameter int FifoDepth  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sampleValid,
    input  logic [InputWidth-1:0]      sampleData,
    output logic                       sampleReady,
    output logic                       firInputValid,
    output logic [InputWidth-1:0]      firInput,
    input  logic                       firOutputValid,
    output logic                       busy,
    output logic [$clog2(FifoDepth):0] level,
    output logic                       protoErr
);

    feeder_state_t         state;
    feeder_state_t         state_next;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [InputWidth-1:0] head;

    assign sampleReady   = !rst && !full;
    assign push          = sampleValid && sampleReady;
    assign firInputValid = (state == ISSUE);
    assign busy          = (state != IDLE);

    sync_fifo #(
        .InputWidth(InputWidth),
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .data (sampleData),
        .head (head),
        .level(level),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (firOutputValid) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            firInput <= '0;
            protoErr <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                firInput <= head;
            end
            // A completion the FIR should not be able to produce yet.
            if (firOutputValid && (state != WAIT)) begin
                protoErr <= 1'b1;
            end
        end
    end

endmodule
